// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, opcode constants and the
// immediate-extension helper used by the decode stage.
package cpu_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_REG_NUM = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Logical immediates are zero-extended, lui goes to the upper half,
    // everything else (arith, loads/stores, branches) is sign-extended.
    function automatic logic [31:0] ext_imm(input logic [31:0] ir);
        logic [31:0] imm;
        case (ir[31:26])
            OP_ANDI, OP_ORI, OP_XORI: imm = {16'h0000, ir[15:0]};
            OP_LUI:                   imm = {ir[15:0], 16'h0000};
            default:                  imm = {{16{ir[15]}}, ir[15:0]};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32-entry register file: two combinational read ports, one synchronous write
// port, synchronous clear, r0 hardwired to zero and write-through bypass.
module reg_file
    import cpu_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int REG_NUM = DEF_REG_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] mem [REG_NUM];
    logic              wr_live;

    assign wr_live = we && (waddr != '0);

    // rst wins over a concurrent write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) mem[i] <= '0;
        end else if (wr_live) begin
            mem[waddr] <= wdata;
        end
    end

    // A write landing this cycle is forwarded so the reader never sees stale data.
    assign rdata_a = (raddr_a == '0)                 ? '0    :
                     (wr_live && waddr == raddr_a)   ? wdata : mem[raddr_a];
    assign rdata_b = (raddr_b == '0)                 ? '0    :
                     (wr_live && waddr == raddr_b)   ? wdata : mem[raddr_b];

endmodule

// File: rtl/id_seg.sv
// Instruction-decode stage: register read, immediate / jump-target formation
// and the ID/EX pipeline latch with hazard stall and branch flush.
module id_seg
    import cpu_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int REG_NUM = DEF_REG_NUM,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] NPCi,
    input  logic [DATA_W-1:0] IRi,
    input  logic [DATA_W-1:0] PCi,
    input  logic              wbEn,
    input  logic [ADDR_W-1:0] wbAddr,
    input  logic [DATA_W-1:0] wbData,
    output logic [DATA_W-1:0] NPCo,
    output logic [DATA_W-1:0] PCo,
    output logic [DATA_W-1:0] IRo,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] Imm,
    output logic [DATA_W-1:0] JTgt,
    output logic [ADDR_W-1:0] rs,
    output logic [ADDR_W-1:0] rt,
    output logic [ADDR_W-1:0] rd,
    output logic              valid
);

    logic [ADDR_W-1:0] rs_d, rt_d, rd_d;
    logic [DATA_W-1:0] a_d, b_d, imm_d, jtgt_d;

    assign rs_d   = IRi[25:21];
    assign rt_d   = IRi[20:16];
    assign rd_d   = IRi[15:11];
    assign imm_d  = ext_imm(IRi);
    assign jtgt_d = {NPCi[31:28], IRi[25:0], 2'b00};

    reg_file #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .REG_NUM(REG_NUM)
    ) u_rf (
        .clk    (clk),
        .rst    (rst),
        .raddr_a(rs_d),
        .rdata_a(a_d),
        .raddr_b(rt_d),
        .rdata_b(b_d),
        .we     (wbEn),
        .waddr  (wbAddr),
        .wdata  (wbData)
    );

    // Latch control, evaluated per edge: rst and flush both load a bubble
    // (NOP, all fields zero, valid=0); stall freezes every output including
    // valid; otherwise the decoded instruction is loaded with valid=1.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            NPCo  <= '0;
            PCo   <= '0;
            IRo   <= NOP_INSTR;
            A     <= '0;
            B     <= '0;
            Imm   <= '0;
            JTgt  <= '0;
            rs    <= '0;
            rt    <= '0;
            rd    <= '0;
            valid <= 1'b0;
        end else if (!stall) begin
            NPCo  <= NPCi;
            PCo   <= PCi;
            IRo   <= IRi;
            A     <= a_d;
            B     <= b_d;
            Imm   <= imm_d;
            JTgt  <= jtgt_d;
            rs    <= rs_d;
            rt    <= rt_d;
            rd    <= rd_d;
            valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_seg.sv
// Bench for id_seg: a reference model pushes the expected ID/EX latch contents
// when each step is driven; the value is popped and compared after the edge.
module tb_id_seg;

    typedef struct packed {
        logic [31:0] npc;
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] jtgt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        valid;
    } out_t;

    localparam int OUT_W = $bits(out_t);

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] NPCi, IRi, PCi;
    logic        wbEn;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic [31:0] NPCo, PCo, IRo, A, B, Imm, JTgt;
    logic [4:0]  rs, rt, rd;
    logic        valid;

    logic [OUT_W-1:0] exp_q[$];
    logic [31:0]      mreg [32];
    out_t             mcur;
    int               errors = 0;
    int               checks = 0;

    id_seg dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .flush (flush),
        .NPCi  (NPCi),
        .IRi   (IRi),
        .PCi   (PCi),
        .wbEn  (wbEn),
        .wbAddr(wbAddr),
        .wbData(wbData),
        .NPCo  (NPCo),
        .PCo   (PCo),
        .IRo   (IRo),
        .A     (A),
        .B     (B),
        .Imm   (Imm),
        .JTgt  (JTgt),
        .rs    (rs),
        .rt    (rt),
        .rd    (rd),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_imm(input logic [31:0] ir);
        case (ir[31:26])
            6'h0C, 6'h0D, 6'h0E: return {16'h0000, ir[15:0]};
            6'h0F:               return {ir[15:0], 16'h0000};
            default:             return {{16{ir[15]}}, ir[15:0]};
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] idx, input logic we,
                                               input logic [4:0] wa, input logic [31:0] wd);
        if (idx == 5'd0) return 32'h0;
        if (we && wa == idx) return wd;
        return mreg[idx];
    endfunction

    function automatic out_t get_obs();
        out_t o;
        o.npc = NPCo; o.pc = PCo; o.ir = IRo; o.a = A; o.b = B;
        o.imm = Imm; o.jtgt = JTgt; o.rs = rs; o.rt = rt; o.rd = rd; o.valid = valid;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, push the model's prediction, then compare after the edge.
    task automatic step(input string tag, input logic r, input logic f, input logic s,
                        input logic [31:0] npc, input logic [31:0] ir, input logic [31:0] pc,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
        out_t n;
        out_t o;
        logic [OUT_W-1:0] e;
        rst = r; flush = f; stall = s;
        NPCi = npc; IRi = ir; PCi = pc;
        wbEn = we; wbAddr = wa; wbData = wd;
        if (r) begin
            n = '0;
            for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
        end else begin
            if (f) begin
                n = '0;
            end else if (s) begin
                n = mcur;
            end else begin
                n.npc   = npc;
                n.pc    = pc;
                n.ir    = ir;
                n.rs    = ir[25:21];
                n.rt    = ir[20:16];
                n.rd    = ir[15:11];
                n.a     = model_read(ir[25:21], we, wa, wd);
                n.b     = model_read(ir[20:16], we, wa, wd);
                n.imm   = model_imm(ir);
                n.jtgt  = {npc[31:28], ir[25:0], 2'b00};
                n.valid = 1'b1;
            end
            if (we && wa != 5'd0) mreg[wa] = wd;
        end
        mcur = n;
        exp_q.push_back(n);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        o = get_obs();
        checks++;
        assert (o === out_t'(e)) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    initial begin
        logic [31:0] rir;
        logic [5:0]  ops [6];
        ops[0] = 6'h00; ops[1] = 6'h08; ops[2] = 6'h0D; ops[3] = 6'h0F; ops[4] = 6'h02; ops[5] = 6'h0C;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        NPCi = '0; IRi = '0; PCi = '0; wbEn = 1'b0; wbAddr = '0; wbData = '0;
        mcur = '0;

        // Reset held two cycles with a write-back pending: rst must win.
        step("rst0", 1, 0, 0, 32'h4, 32'h00A00020, 32'h0, 1, 5'd5, 32'h55);
        step("rst1", 1, 0, 0, 32'h4, 32'h00A00020, 32'h0, 1, 5'd5, 32'h55);
        chk("rst_valid", {31'h0, valid}, 32'h0);
        chk("rst_ir", IRo, 32'h0);
        step("rd_r5_after_rst", 0, 0, 0, 32'h8, 32'h00A00020, 32'h4, 0, 5'd0, 32'h0);
        chk("r5_zero", A, 32'h0);

        // Write then read.
        step("wr_r5", 0, 0, 0, 32'hC, 32'h0, 32'h8, 1, 5'd5, 32'hDEADBEEF);
        step("rd_r5", 0, 0, 0, 32'h10, 32'h00A00020, 32'hC, 0, 5'd0, 32'h0);
        chk("r5_val", A, 32'hDEADBEEF);
        chk("r5_valid", {31'h0, valid}, 32'h1);
        step("wr_r0", 0, 0, 0, 32'h14, 32'h0, 32'h10, 1, 5'd0, 32'h1234);
        step("rd_r0", 0, 0, 0, 32'h18, 32'h00000020, 32'h14, 0, 5'd0, 32'h0);
        chk("r0_zero", A, 32'h0);

        // Bypass on both ports.
        step("bypass_a", 0, 0, 0, 32'h1C, 32'h00E00020, 32'h18, 1, 5'd7, 32'd99);
        chk("bypass_a_val", A, 32'd99);
        step("bypass_b", 0, 0, 0, 32'h20, 32'h00A70020, 32'h1C, 1, 5'd7, 32'd123);
        chk("bypass_b_val", B, 32'd123);
        chk("bypass_b_a", A, 32'hDEADBEEF);

        // Immediates and jump target.
        step("ori", 0, 0, 0, 32'h24, 32'h3400FFFF, 32'h20, 0, 5'd0, 32'h0);
        chk("ori_imm", Imm, 32'h0000FFFF);
        step("addi", 0, 0, 0, 32'h28, 32'h2000FFFF, 32'h24, 0, 5'd0, 32'h0);
        chk("addi_imm", Imm, 32'hFFFFFFFF);
        step("lui", 0, 0, 0, 32'h2C, 32'h3C001234, 32'h28, 0, 5'd0, 32'h0);
        chk("lui_imm", Imm, 32'h12340000);
        step("j", 0, 0, 0, 32'h40000004, 32'h08000010, 32'h40000000, 0, 5'd0, 32'h0);
        chk("j_tgt", JTgt, 32'h40000040);
        chk("j_rs", {27'h0, rs}, 32'h0);

        // Stall three cycles (with a write-back to the held rs), then flush over stall.
        step("hold_load", 0, 0, 0, 32'h34, 32'h34A5ABCD, 32'h30, 0, 5'd0, 32'h0);
        for (int i = 0; i < 3; i++)
            step("stall", 0, 0, 1, $urandom, $urandom, $urandom, 1, 5'd5, $urandom);
        chk("stall_ir", IRo, 32'h34A5ABCD);
        chk("stall_imm", Imm, 32'h0000ABCD);
        chk("stall_a", A, 32'hDEADBEEF);
        step("flush", 0, 1, 1, 32'h38, 32'h2000FFFF, 32'h34, 0, 5'd0, 32'h0);
        chk("flush_ir", IRo, 32'h0);
        chk("flush_valid", {31'h0, valid}, 32'h0);
        step("after_flush", 0, 0, 0, 32'h3C, 32'h2000FFFF, 32'h38, 0, 5'd0, 32'h0);
        chk("after_flush_ir", IRo, 32'h2000FFFF);

        // Randomised mix of loads, write-backs, stalls and flushes.
        for (int i = 0; i < 40; i++) begin
            rir = $urandom;
            rir[31:26] = ops[$urandom_range(0, 5)];
            step("rand", 0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                 $urandom, rir, $urandom, $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 31)), $urandom);
        end

        // Mid-operation reset clears the register file.
        step("wr_r3", 0, 0, 0, 32'h44, 32'h0, 32'h40, 1, 5'd3, 32'd7);
        step("rd_r3", 0, 0, 0, 32'h48, 32'h00600020, 32'h44, 0, 5'd0, 32'h0);
        chk("r3_val", A, 32'd7);
        step("mid_rst", 1, 0, 0, 32'h4C, 32'h00600020, 32'h48, 0, 5'd0, 32'h0);
        chk("mid_rst_valid", {31'h0, valid}, 32'h0);
        step("rd_r3_after_rst", 0, 0, 0, 32'h50, 32'h00600020, 32'h4C, 0, 5'd0, 32'h0);
        chk("r3_zero", A, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
